// File: rtl/gvp_multi_if.sv
// Bus bundle for the gvp_multi vector-program core: program-write port, control, and position/trigger outputs.
// Optional sat_flag member exists only when GVP_MULTI_SAT_EN is defined.
interface gvp_multi_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int OPT_W  = 32
) ();
  logic                     start;
  logic                     pause;
  logic [OPT_W-1:0]         reset_options;
  // Write handshake: a slot is written on the cycle wr_valid & wr_ready are both high;
  // wr_valid without wr_ready is dropped, never queued, and wr_ready does not depend on wr_valid.
  logic                     wr_valid;
  logic                     wr_ready;
  logic [ADDR_W-1:0]        wr_addr;
  logic [31:0]              wr_n;
  logic [31:0]              wr_nii;
  logic [31:0]              wr_nrep;
  logic [ADDR_W:0]          wr_next;
  logic [31:0]              wr_deci;
  logic [OPT_W-1:0]         wr_opt;
  logic [NUM_CH*DATA_W-1:0] wr_delta;
  logic [NUM_CH*DATA_W-1:0] pos_tdata;
  logic                     pos_tvalid;
  logic [OPT_W-1:0]         options;
  logic [1:0]               store_data;
  logic                     busy;
  logic                     hold;
  logic                     finished;
  logic                     prog_err;
  logic [31:0]              section_cnt;
  logic [1:0]               fsm_state;
`ifdef GVP_MULTI_SAT_EN
  logic [NUM_CH-1:0]        sat_flag;
`endif

  modport master (
    output start, pause, reset_options, wr_valid, wr_addr, wr_n, wr_nii, wr_nrep,
           wr_next, wr_deci, wr_opt, wr_delta,
    input  wr_ready, pos_tdata, pos_tvalid, options, store_data, busy, hold,
           finished, prog_err, section_cnt, fsm_state
`ifdef GVP_MULTI_SAT_EN
    , input sat_flag
`endif
  );

  modport slave (
    input  start, pause, reset_options, wr_valid, wr_addr, wr_n, wr_nii, wr_nrep,
           wr_next, wr_deci, wr_opt, wr_delta,
    output wr_ready, pos_tdata, pos_tvalid, options, store_data, busy, hold,
           finished, prog_err, section_cnt, fsm_state
`ifdef GVP_MULTI_SAT_EN
    , output sat_flag
`endif
  );
endinterface

// File: rtl/gvp_multi.sv
// General Vector Program core: walks a list of vector sections, stepping NUM_CH signed positions.
// Define GVP_MULTI_SAT_EN for saturating channel adds with a sticky per-channel sat_flag.
module gvp_multi #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int OPT_W  = 32
) (
  input logic         a_clk,
  input logic         reset,
  gvp_multi_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int PW    = NUM_CH * DATA_W;

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, STEP = 2'd2, FINISH = 2'd3} state_t;

  logic [31:0]       n_mem    [DEPTH];
  logic [31:0]       nii_mem  [DEPTH];
  logic [31:0]       nrep_mem [DEPTH];
  logic [ADDR_W:0]   next_mem [DEPTH];
  logic [31:0]       deci_mem [DEPTH];
  logic [OPT_W-1:0]  opt_mem  [DEPTH];
  logic [PW-1:0]     delta_mem[DEPTH];
  logic [31:0]       loop_cnt [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pvc;
  logic              jmp_err;
  logic [31:0]       i_cnt, ii_cnt, dcnt;
  logic [PW-1:0]     pos, pos_nxt, cur_delta;
  logic              tick, do_add, data_pt, sec_done, holding;
  logic              wr_fire;
  logic [ADDR_W+1:0] tgt;
  logic              pos_tvalid_q, finished_q, prog_err_q;
  logic [1:0]        store_q;
  logic [31:0]       section_cnt_q;
  logic [OPT_W-1:0]  options_q;
`ifdef GVP_MULTI_SAT_EN
  logic [NUM_CH-1:0] sat_hit, sat_q;
`endif

  assign bus.wr_ready = (state_q == IDLE) || (state_q == FINISH);
  assign wr_fire      = bus.wr_valid & bus.wr_ready;
  assign cur_delta    = delta_mem[pvc];

  always_ff @(posedge a_clk) begin
    if (wr_fire) begin
      n_mem[bus.wr_addr]     <= bus.wr_n;
      nii_mem[bus.wr_addr]   <= bus.wr_nii;
      nrep_mem[bus.wr_addr]  <= bus.wr_nrep;
      next_mem[bus.wr_addr]  <= bus.wr_next;
      deci_mem[bus.wr_addr]  <= bus.wr_deci;
      opt_mem[bus.wr_addr]   <= bus.wr_opt;
      delta_mem[bus.wr_addr] <= bus.wr_delta;
    end
  end

  // Loop counters live beside the program memory; reset re-arms every slot from its stored nrep.
  always_ff @(posedge a_clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) loop_cnt[k] <= nrep_mem[k];
    end else if (wr_fire) begin
      loop_cnt[bus.wr_addr] <= bus.wr_nrep;
    end else if (sec_done) begin
      if (loop_cnt[pvc] != 32'd0) loop_cnt[pvc] <= loop_cnt[pvc] - 32'd1;
      else                        loop_cnt[pvc] <= nrep_mem[pvc];
    end
  end

  // Target computed two bits wider than pvc so both underflow and overflow show in the top bits.
  always_comb begin
    if (loop_cnt[pvc] != 32'd0) tgt = {2'b00, pvc} + {next_mem[pvc][ADDR_W], next_mem[pvc]};
    else                        tgt = {2'b00, pvc} + {{(ADDR_W+1){1'b0}}, 1'b1};
  end

  always_comb begin
    pos_nxt = pos;
`ifdef GVP_MULTI_SAT_EN
    sat_hit = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      logic [DATA_W:0] sum;
      sum = {pos[c*DATA_W+DATA_W-1], pos[c*DATA_W +: DATA_W]}
          + {cur_delta[c*DATA_W+DATA_W-1], cur_delta[c*DATA_W +: DATA_W]};
      if (sum[DATA_W] != sum[DATA_W-1]) begin
        pos_nxt[c*DATA_W +: DATA_W] = sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                                                  : {1'b0, {(DATA_W-1){1'b1}}};
        sat_hit[c] = 1'b1;
      end else begin
        pos_nxt[c*DATA_W +: DATA_W] = sum[DATA_W-1:0];
      end
    end
`else
    for (int c = 0; c < NUM_CH; c++)
      pos_nxt[c*DATA_W +: DATA_W] = pos[c*DATA_W +: DATA_W] + cur_delta[c*DATA_W +: DATA_W];
`endif
  end

  always_ff @(posedge a_clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    tick     = 1'b0;
    do_add   = 1'b0;
    data_pt  = 1'b0;
    sec_done = 1'b0;
    holding  = 1'b0;
    case (state_q)
      IDLE, FINISH: if (bus.start) state_d = LOAD;
      LOAD:         state_d = (jmp_err || n_mem[pvc] == 32'd0) ? FINISH : STEP;
      STEP: begin
        tick = (dcnt == 32'd0);
        if (tick) begin
          if (ii_cnt != 32'd0) begin
            do_add = 1'b1;
          end else if (bus.pause) begin
            holding = 1'b1;
          end else begin
            do_add  = 1'b1;
            data_pt = 1'b1;
            if (i_cnt == 32'd0) begin
              sec_done = 1'b1;
              state_d  = LOAD;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge a_clk) begin
    if (reset) begin
      pos           <= '0;
      pos_tvalid_q  <= 1'b0;
      store_q       <= 2'd0;
      finished_q    <= 1'b0;
      prog_err_q    <= 1'b0;
      section_cnt_q <= 32'd0;
      options_q     <= bus.reset_options;
      pvc           <= '0;
      jmp_err       <= 1'b0;
      i_cnt         <= 32'd0;
      ii_cnt        <= 32'd0;
      dcnt          <= 32'd0;
`ifdef GVP_MULTI_SAT_EN
      sat_q         <= '0;
`endif
    end else begin
      pos_tvalid_q <= do_add;
      store_q      <= data_pt ? 2'd1 : 2'd0;
      if (do_add) pos <= pos_nxt;
`ifdef GVP_MULTI_SAT_EN
      if (do_add) sat_q <= sat_q | sat_hit;
`endif
      case (state_q)
        IDLE, FINISH: begin
          options_q <= bus.reset_options;
          if (bus.start) begin
            pvc           <= '0;
            jmp_err       <= 1'b0;
            section_cnt_q <= 32'd0;
            finished_q    <= 1'b0;
            prog_err_q    <= 1'b0;
`ifdef GVP_MULTI_SAT_EN
            sat_q         <= '0;
`endif
          end
        end
        LOAD: begin
          if (jmp_err) begin
            finished_q <= 1'b1;
            prog_err_q <= 1'b1;
            options_q  <= bus.reset_options;
          end else if (n_mem[pvc] == 32'd0) begin
            finished_q <= 1'b1;
            options_q  <= bus.reset_options;
            store_q    <= 2'd2;
          end else begin
            i_cnt     <= n_mem[pvc] - 32'd1;
            ii_cnt    <= nii_mem[pvc];
            dcnt      <= deci_mem[pvc];
            options_q <= opt_mem[pvc];
            store_q   <= 2'd2;
          end
        end
        STEP: begin
          if (!tick) begin
            dcnt <= dcnt - 32'd1;
          end else if (!holding) begin
            dcnt <= deci_mem[pvc];
            if (ii_cnt != 32'd0) begin
              ii_cnt <= ii_cnt - 32'd1;
            end else if (i_cnt != 32'd0) begin
              i_cnt  <= i_cnt - 32'd1;
              ii_cnt <= nii_mem[pvc];
            end else begin
              section_cnt_q <= section_cnt_q + 32'd1;
              pvc           <= tgt[ADDR_W-1:0];
              jmp_err       <= tgt[ADDR_W+1] | tgt[ADDR_W];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.pos_tdata   = pos;
  assign bus.pos_tvalid  = pos_tvalid_q;
  assign bus.options     = options_q;
  assign bus.store_data  = store_q;
  assign bus.busy        = (state_q == LOAD) || (state_q == STEP);
  assign bus.hold        = holding;
  assign bus.finished    = finished_q;
  assign bus.prog_err    = prog_err_q;
  assign bus.section_cnt = section_cnt_q;
  assign bus.fsm_state   = state_q;
`ifdef GVP_MULTI_SAT_EN
  assign bus.sat_flag    = sat_q;
`endif
endmodule

// File: tb/tb_gvp_multi.sv
// Directed bench for gvp_multi: timing, decimation, loops, pause/reset, jump errors, write gating, arithmetic.
module tb_gvp_multi;
  localparam int NUM_CH = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int OPT_W  = 32;
  localparam logic [31:0] RST_OPT = 32'hA5A5_0001;

  logic a_clk = 1'b0;
  logic reset = 1'b1;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  always #5 a_clk = ~a_clk;

  gvp_multi_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .OPT_W(OPT_W)) bus ();

  gvp_multi #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .OPT_W(OPT_W)) dut (
    .a_clk (a_clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] ch0, ch1;
  assign ch0 = bus.pos_tdata[31:0];
  assign ch1 = bus.pos_tdata[63:32];

  // ---------------- driver tasks ----------------
  task automatic step_n(input int n);
    repeat (n) @(negedge a_clk);
  endtask

  task automatic apply_reset;
    reset = 1'b1;
    @(negedge a_clk);
    reset = 1'b0;
  endtask

  task automatic write_slot(input logic [3:0] a, input logic [31:0] n, input logic [31:0] nii,
                            input logic [31:0] nrep, input logic [4:0] nxt,
                            input logic [31:0] deci, input logic [31:0] opt, input logic [31:0] d);
    bus.wr_addr  = a;
    bus.wr_n     = n;
    bus.wr_nii   = nii;
    bus.wr_nrep  = nrep;
    bus.wr_next  = nxt;
    bus.wr_deci  = deci;
    bus.wr_opt   = opt;
    bus.wr_delta = {32'd0, 32'd0, 32'd0 - d, d};
    bus.wr_valid = 1'b1;
    @(negedge a_clk);
    bus.wr_valid = 1'b0;
  endtask

  task automatic pulse_start;
    bus.start = 1'b1;
    @(negedge a_clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k;
    k = 0;
    while (!bus.finished && k < budget) begin
      @(negedge a_clk);
      k++;
    end
    vec_cnt++;
    if (bus.finished !== 1'b1) begin
      err_cnt++;
      $display("FAIL %s_timeout: finished=%b after %0d cycles, required 1", name, bus.finished, k);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    reset = 1'b1;
    step_n(2);
    vec_cnt++; if (bus.pos_tdata !== '0) begin err_cnt++; $display("FAIL rst_pos: got %h required 0", bus.pos_tdata); end
    vec_cnt++; if ({bus.pos_tvalid, bus.store_data, bus.busy, bus.hold, bus.finished, bus.prog_err} !== 7'd0) begin
      err_cnt++; $display("FAIL rst_flags: got %b required 0", {bus.pos_tvalid, bus.store_data, bus.busy, bus.hold, bus.finished, bus.prog_err}); end
    vec_cnt++; if (bus.section_cnt !== 32'd0) begin err_cnt++; $display("FAIL rst_section_cnt: got %0d required 0", bus.section_cnt); end
    vec_cnt++; if (bus.options !== RST_OPT) begin err_cnt++; $display("FAIL rst_options: got %h required %h", bus.options, RST_OPT); end
    vec_cnt++; if (bus.fsm_state !== 2'd0 || bus.wr_ready !== 1'b1) begin
      err_cnt++; $display("FAIL rst_state: state=%0d wr_ready=%b required 0/1", bus.fsm_state, bus.wr_ready); end
    reset = 1'b0;
  endtask

  task automatic test_single_section;
    logic [31:0] tr[$];
    logic [31:0] st[$];
    logic [31:0] exp_q[$];
    logic [31:0] opt_seen;
    int s2;
    s2 = 0;
    opt_seen = 32'd0;
    apply_reset();
    write_slot(4'd0, 32'd3, 32'd1, 32'd0, 5'd0, 32'd0, 32'h0000_0011, 32'd5);
    write_slot(4'd1, 32'd0, 32'd0, 32'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    pulse_start();
    for (int k = 0; k < 40 && !bus.finished; k++) begin
      @(negedge a_clk);
      if (bus.pos_tvalid) tr.push_back(ch0);
      if (bus.store_data == 2'd1) st.push_back(ch0);
      if (bus.store_data == 2'd2) s2++;
      if (bus.busy && bus.pos_tvalid) opt_seen = bus.options;
    end
    vec_cnt++; if (bus.finished !== 1'b1) begin err_cnt++; $display("FAIL single_finished: got %b required 1", bus.finished); end
    exp_q = '{32'd5, 32'd10, 32'd15, 32'd20, 32'd25, 32'd30};
    vec_cnt++;
    if (tr.size() != 6) begin
      err_cnt++; $display("FAIL single_add_count: got %0d required 6", tr.size());
    end else begin
      for (int k = 0; k < 6; k++)
        if (tr[k] !== exp_q[k]) begin err_cnt++; $display("FAIL single_trace[%0d]: got %0d required %0d", k, tr[k], exp_q[k]); end
    end
    exp_q = '{32'd10, 32'd20, 32'd30};
    vec_cnt++;
    if (st.size() != 3) begin
      err_cnt++; $display("FAIL single_store_count: got %0d required 3", st.size());
    end else begin
      for (int k = 0; k < 3; k++)
        if (st[k] !== exp_q[k]) begin err_cnt++; $display("FAIL single_store[%0d]: got %0d required %0d", k, st[k], exp_q[k]); end
    end
    vec_cnt++; if (s2 != 2) begin err_cnt++; $display("FAIL single_headers: got %0d required 2", s2); end
    vec_cnt++; if (bus.section_cnt !== 32'd1) begin err_cnt++; $display("FAIL single_section_cnt: got %0d required 1", bus.section_cnt); end
    vec_cnt++; if (ch1 !== 32'hFFFF_FFE2) begin err_cnt++; $display("FAIL single_ch1: got %h required ffffffe2", ch1); end
    vec_cnt++; if (opt_seen !== 32'h11) begin err_cnt++; $display("FAIL single_opt_active: got %h required 11", opt_seen); end
    step_n(1);
    vec_cnt++; if (bus.options !== RST_OPT) begin err_cnt++; $display("FAIL single_opt_finish: got %h required %h", bus.options, RST_OPT); end
  endtask

  task automatic test_decimation;
    int cyc[$];
    apply_reset();
    write_slot(4'd0, 32'd2, 32'd0, 32'd0, 5'd0, 32'd3, 32'd0, 32'd7);
    write_slot(4'd1, 32'd0, 32'd0, 32'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    pulse_start();
    for (int k = 0; k < 60 && !bus.finished; k++) begin
      @(negedge a_clk);
      if (bus.pos_tvalid) cyc.push_back(k);
    end
    vec_cnt++; if (cyc.size() != 2) begin err_cnt++; $display("FAIL deci_adds: got %0d required 2", cyc.size()); end
    vec_cnt++;
    if (cyc.size() == 2 && cyc[1] - cyc[0] != 4) begin
      err_cnt++; $display("FAIL deci_gap: got %0d required 4", cyc[1] - cyc[0]);
    end
    vec_cnt++; if (ch0 !== 32'd14) begin err_cnt++; $display("FAIL deci_pos: got %0d required 14", ch0); end
  endtask

  task automatic test_loop;
    apply_reset();
    write_slot(4'd0, 32'd1, 32'd0, 32'd0, 5'd0, 32'd0, 32'd0, 32'd1);
    write_slot(4'd1, 32'd1, 32'd0, 32'd2, 5'b11111, 32'd0, 32'd0, 32'd10);
    write_slot(4'd2, 32'd0, 32'd0, 32'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    pulse_start();
    wait_done("loop1", 100);
    vec_cnt++; if (ch0 !== 32'd33) begin err_cnt++; $display("FAIL loop_pos: got %0d required 33", ch0); end
    vec_cnt++; if (bus.section_cnt !== 32'd6) begin err_cnt++; $display("FAIL loop_sections: got %0d required 6", bus.section_cnt); end
    pulse_start();
    wait_done("loop2", 100);
    vec_cnt++; if (ch0 !== 32'd66) begin err_cnt++; $display("FAIL loop_rerun_pos: got %0d required 66", ch0); end
    vec_cnt++; if (bus.section_cnt !== 32'd6) begin err_cnt++; $display("FAIL loop_rerun_sections: got %0d required 6", bus.section_cnt); end
  endtask

  task automatic test_pause_reset;
    apply_reset();
    write_slot(4'd0, 32'd2, 32'd2, 32'd0, 5'd0, 32'd0, 32'd0, 32'd3);
    write_slot(4'd1, 32'd0, 32'd0, 32'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    bus.pause = 1'b1;
    pulse_start();
    step_n(8);
    vec_cnt++; if (ch0 !== 32'd6) begin err_cnt++; $display("FAIL pause_pos: got %0d required 6", ch0); end
    vec_cnt++; if (bus.hold !== 1'b1 || bus.busy !== 1'b1) begin
      err_cnt++; $display("FAIL pause_hold: hold=%b busy=%b required 1/1", bus.hold, bus.busy); end
    bus.pause = 1'b0;
    @(negedge a_clk);
    vec_cnt++; if (ch0 !== 32'd9 || bus.store_data !== 2'd1 || bus.hold !== 1'b0) begin
      err_cnt++; $display("FAIL pause_release: pos=%0d store=%0d hold=%b required 9/1/0", ch0, bus.store_data, bus.hold); end
    wait_done("pause", 50);
    vec_cnt++; if (ch0 !== 32'd18) begin err_cnt++; $display("FAIL pause_final: got %0d required 18", ch0); end
    pulse_start();
    step_n(2);
    vec_cnt++; if (bus.busy !== 1'b1) begin err_cnt++; $display("FAIL midrun_busy: got %b required 1", bus.busy); end
    reset = 1'b1;
    @(negedge a_clk);
    vec_cnt++; if (bus.pos_tdata !== '0 || bus.busy !== 1'b0 || bus.fsm_state !== 2'd0) begin
      err_cnt++; $display("FAIL midrun_reset: pos=%h busy=%b state=%0d required 0/0/0", bus.pos_tdata, bus.busy, bus.fsm_state); end
    reset = 1'b0;
  endtask

  task automatic test_jump_err_gating;
    apply_reset();
    write_slot(4'd0, 32'd1, 32'd0, 32'd0, 5'd0, 32'd0, 32'd0, 32'd1);
    write_slot(4'd1, 32'd1, 32'd0, 32'd1, 5'b11100, 32'd5, 32'd0, 32'd2);
    write_slot(4'd2, 32'd0, 32'd0, 32'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    pulse_start();
    step_n(1);
    vec_cnt++; if (bus.wr_ready !== 1'b0) begin err_cnt++; $display("FAIL gate_ready: got %b required 0", bus.wr_ready); end
    bus.wr_addr  = 4'd0;
    bus.wr_n     = 32'd0;
    bus.wr_delta = '0;
    bus.wr_valid = 1'b1;
    step_n(3);
    bus.wr_valid = 1'b0;
    wait_done("jump", 60);
    vec_cnt++; if (bus.prog_err !== 1'b1 || bus.store_data !== 2'd0) begin
      err_cnt++; $display("FAIL jump_err: prog_err=%b store=%0d required 1/0", bus.prog_err, bus.store_data); end
    vec_cnt++; if (ch0 !== 32'd3 || bus.section_cnt !== 32'd2) begin
      err_cnt++; $display("FAIL jump_state: pos=%0d sections=%0d required 3/2", ch0, bus.section_cnt); end
    pulse_start();
    wait_done("gate", 60);
    vec_cnt++; if (ch0 !== 32'd6 || bus.section_cnt !== 32'd2 || bus.prog_err !== 1'b0) begin
      err_cnt++; $display("FAIL gate_memory: pos=%0d sections=%0d prog_err=%b required 6/2/0", ch0, bus.section_cnt, bus.prog_err); end
  endtask

  task automatic test_arith;
    apply_reset();
    write_slot(4'd0, 32'd1, 32'd0, 32'd0, 5'd0, 32'd0, 32'd0, 32'h7FFF_FFF0);
    write_slot(4'd1, 32'd1, 32'd0, 32'd0, 5'd0, 32'd0, 32'd0, 32'h0000_0020);
    write_slot(4'd2, 32'd0, 32'd0, 32'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    pulse_start();
    wait_done("arith", 40);
`ifdef GVP_MULTI_SAT_EN
    vec_cnt++; if (ch0 !== 32'h7FFF_FFFF || ch1 !== 32'h8000_0000) begin
      err_cnt++; $display("FAIL sat_clip: ch0=%h ch1=%h required 7fffffff/80000000", ch0, ch1); end
    vec_cnt++; if (bus.sat_flag !== 4'b0011) begin err_cnt++; $display("FAIL sat_flag: got %b required 0011", bus.sat_flag); end
`else
    vec_cnt++; if (ch0 !== 32'h8000_0010 || ch1 !== 32'h7FFF_FFF0) begin
      err_cnt++; $display("FAIL wrap_add: ch0=%h ch1=%h required 80000010/7ffffff0", ch0, ch1); end
`endif
  endtask

  initial begin
    bus.start         = 1'b0;
    bus.pause         = 1'b0;
    bus.reset_options = RST_OPT;
    bus.wr_valid      = 1'b0;
    bus.wr_addr       = '0;
    bus.wr_n          = '0;
    bus.wr_nii        = '0;
    bus.wr_nrep       = '0;
    bus.wr_next       = '0;
    bus.wr_deci       = '0;
    bus.wr_opt        = '0;
    bus.wr_delta      = '0;
    test_reset();
    test_single_section();
    test_decimation();
    test_loop();
    test_pause_reset();
    test_jump_err_gating();
    test_arith();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/gvp_multi.md
Name: gvp_multi

Overview:
- Parametrised next-generation General Vector Program core for the RPSPMC controller.
- Executes a programmable list of vector sections that incrementally move NUM_CH signed position channels, e.g. X, Y, Z, U, bias and aux.
- Supports per-section step decimation, nested loops via relative jumps, pause-at-data-point, and data-store triggers.
- Runs entirely on a_clk, using a clock-enable decimator instead of a derived clock; feeds the DAC/scan path and the data-capture FIFO trigger logic.

Parameters:
- NUM_CH, 4, number of position channels
- DATA_W, 32, channel and delta width (signed)
- ADDR_W, 4, program address width; DEPTH = 2**ADDR_W vector slots
- OPT_W, 32, section option word width

Ports:
- a_clk  in  1  system clock
- reset  in  1  synchronous, active-high; clears run state and positions; program memory is retained
- start  in  1  pulse; begins execution at slot 0 from IDLE or FINISH, ignored otherwise
- pause  in  1  level; holds execution at the next data point
- reset_options  in  OPT_W  option word driven while IDLE or FINISH
- wr_valid  in  1  vector write request
- wr_ready  out  1  high only in IDLE or FINISH
- wr_addr  in  ADDR_W  target slot
- wr_n  in  32  data points in section; 0 marks end of program
- wr_nii  in  32  intermediate steps before each data point
- wr_nrep  in  32  loop repeat count
- wr_next  in  ADDR_W+1  signed relative jump used while loops remain
- wr_deci  in  32  clock enables between steps, 0 = every cycle
- wr_opt  in  OPT_W  section options
- wr_delta  in  NUM_CH*DATA_W  per-channel signed increments, ch0 in LSBs
- pos_tdata  out  NUM_CH*DATA_W  current positions
- pos_tvalid  out  1  one-cycle pulse on the cycle after each position update
- options  out  OPT_W  active option word
- store_data  out  2  one-cycle pulse: 2 = section header, 1 = data point, 0 = none
- busy  out  1  state is LOAD or STEP
- hold  out  1  paused at a data point
- finished  out  1  program ended
- prog_err  out  1  jump target out of range
- section_cnt  out  32  completed sections since start

Behaviour:
- Reset values: all positions 0, pos_tvalid 0, store_data 0, busy 0, hold 0, finished 0, prog_err 0, section_cnt 0, options = reset_options, state IDLE.
- Reset asserted mid-run: state is IDLE on the next cycle; loop counters are reloaded from nrep for every slot.
- Writes: a write is accepted on wr_valid & wr_ready. It stores all fields at wr_addr and sets loop_cnt[wr_addr] = wr_nrep. wr_valid while not ready has no effect and is not queued.
- start in IDLE/FINISH:
  - pvc = 0, section_cnt = 0, finished = 0, prog_err = 0, state LOAD.
  - Positions are not cleared.
- LOAD (one cycle), reading slot pvc:
  - If n == 0: state FINISH, finished = 1, options = reset_options, store_data = 2.
  - Else: i = n-1, ii = nii, dcnt = deci, options = opt, store_data = 2, state STEP.
- STEP: a tick occurs when dcnt == 0.
  - On a non-tick cycle: dcnt decrements.
  - On a tick, dcnt reloads to deci, except when holding.
  - ii != 0: add deltas, ii--.
  - ii == 0 and pause: no add, hold = 1, dcnt stays 0; pause is re-evaluated every cycle and hold clears on the cycle pause drops.
  - ii == 0 and no pause: add deltas, store_data = 1. Then:
    - If i != 0: i--, ii = nii.
    - Else (section done): section_cnt++, state LOAD. If loop_cnt[pvc] != 0, loop_cnt[pvc]--, pvc += next; otherwise loop_cnt[pvc] = nrep, pvc += 1.
- Section length: each section performs exactly n*(nii+1) adds and n data-point stores.
- Jump range: if the new pvc is < 0 or >= DEPTH, the next LOAD goes to FINISH with prog_err = 1 and store_data = 0.
- Arithmetic:
  - Per-channel DATA_W two's-complement add.
  - Wrap-around unless the optional feature is enabled.
  - All channels update in the same cycle.
- Simultaneous events:
  - reset dominates everything.
  - start during LOAD/STEP is ignored.
  - pause asserted on a tick with ii != 0 takes effect only at the data point.
- Latency: deltas appear on pos_tdata one cycle after the tick; store_data pulses in the same cycle as the matching pos_tdata update.
- FINISH: positions hold and options = reset_options until reset or start.

Optional Feature:
- Macro: GVP_MULTI_SAT_EN.
- Defined: each channel add saturates to [-2**(DATA_W-1), 2**(DATA_W-1)-1], and a sticky output sat_flag (NUM_CH bits, one per channel) is set on clipping and cleared by reset or start.
- Undefined: wrap-around add, and the sat_flag port is absent.

Test Plan:
- Single-section timing:
  - Stimulus: slot0 n=3, nii=1, deci=0, delta ch0=+5, slot1 n=0, then start.
  - Response: ch0 updates at 5,10,15,20,25,30; store_data=1 after 10, 20 and 30; store_data=2 twice; finished=1; section_cnt=1.
- Decimation:
  - Stimulus: deci=3, n=2, nii=0.
  - Response: exactly 4 cycles between pos_tvalid pulses; 2 adds total.
- Loop:
  - Stimulus: slot0 n=1, delta +1; slot1 n=1, delta +10, nrep=2, next=-1; slot2 n=0.
  - Response: final ch0 = 33, section_cnt = 6; a second start without rewriting adds the same +33, showing the loop counter reloaded.
- Pause and reset:
  - Stimulus: pause held through the first data point of n=2, nii=2.
  - Response: hold=1 after 2 adds with no further adds while paused; release resumes. reset mid-STEP gives IDLE and zero positions next cycle.
- Jump error and write gating:
  - Stimulus: next=-4 from slot1; then wr_valid asserted while busy.
  - Response: prog_err=1, finished=1; wr_ready=0 while busy and memory unchanged.
- Saturation (GVP_MULTI_SAT_EN):
  - Stimulus: ch0 = 0x7FFFFFF0 with delta 0x20.
  - Response: ch0 clamps at 0x7FFFFFFF and sat_flag[0] = 1.
